// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-bit shift controller for the 16-bit datapath.
// Runs one shift of up to 2^CNT_W-1 positions. It steps the external one-bit shifter once
// per clock and latches the shifter's combinational result back into an accumulator.
// Optional feature: define SHIFT_SEQ_EARLY_EXIT_EN to stop as soon as a step leaves the
// accumulator unchanged (a fixed point). The result is the same, but latency gets shorter.
module shift_sequencer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [15:0]      operand,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic [15:0]      sh_T,
    output logic [1:0]       sh_ctrl,
    input  logic [15:0]      sh_Result
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_t           state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       opr;

    // The shifter sees the accumulator directly. It receives the latched op only while
    // stepping. Both come from registers, so they change only on clock edges.
    assign sh_T    = acc;
    assign sh_ctrl = busy ? opr : 2'b00;

    // Sequencer FSM together with its datapath registers and registered handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= StIdle;
            acc    <= 16'h0000;
            cnt    <= '0;
            opr    <= 2'b00;
            result <= 16'h0000;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        acc <= operand;
                        cnt <= amount;
                        opr <= op;
                        if (amount == '0 || op == 2'b00) begin
                            // Nothing to step: finish straight away with the operand
                            state  <= StDone;
                            result <= operand;
                            ready  <= 1'b1;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            state <= StRun;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= StIdle;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                StRun: begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                    if (sh_Result == acc) begin
                        // Fixed point: further steps cannot change acc
                        state  <= StDone;
                        result <= acc;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        acc <= sh_Result;
                        cnt <= cnt - CntOne;
                        if (cnt == CntOne) begin
                            state  <= StDone;
                            result <= sh_Result;
                            ready  <= 1'b1;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
`else
                    acc <= sh_Result;
                    cnt <= cnt - CntOne;
                    if (cnt == CntOne) begin
                        // Last step: result takes the value acc is being loaded with
                        state  <= StDone;
                        result <= sh_Result;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
`endif
                end

                default: begin
                    state <= StIdle;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
